// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
//
// Iterative 32-bit multiply/divide unit for the EX stage. Executes MULT,
// MULTU, DIV and DIVU at one result bit per cycle and owns the architectural
// HI/LO registers, which MTHI/MTLO can also load directly. While an
// operation is in flight the unit raises o_busy so the hazard logic can
// freeze IF/ID/EX.
//
// Ports
//   i_clk         pipeline clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_start       mul/div instruction valid in EX
//   i_op          00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_operand_a   rs value: multiplicand / dividend
//   i_operand_b   rt value: multiplier / divisor
//   i_write_hi    MTHI: load HI from i_write_data
//   i_write_lo    MTLO: load LO from i_write_data
//   i_write_data  MTHI/MTLO data
//   o_busy        stall request (combinational)
//   o_done        one-cycle pulse after HI/LO receive a mul/div result
//   o_hi, o_lo    HI and LO registers
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for i_start; MTHI/MTLO honoured here only
// MUL    | shift-add multiply, one multiplier bit per cycle
// DIV    | restoring divide, one quotient bit per cycle
// DONE   | result visible in HI/LO; stalled instruction advances
// ---------------------------------------------------------------------------
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  input  logic             i_write_hi,
  input  logic             i_write_lo,
  input  logic [WIDTH-1:0] i_write_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0] LAST_ITER = 5'd31;

  logic [1:0]         r_state;
  logic [4:0]         r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_a_mag;
  logic [WIDTH-1:0]   r_b_mag;
  logic [WIDTH-1:0]   r_a_raw;
  logic               r_neg_res;   // product / quotient must be negated
  logic               r_neg_rem;   // remainder takes the dividend's sign
  logic               r_div_zero;
  // Shared datapath register.
  //   MUL: [63:32] running partial product, [31:0] multiplier shifting right
  //   DIV: [63:32] partial remainder,        [31:0] dividend shifting out /
  //        quotient shifting in
  logic [2*WIDTH-1:0] r_acc;

  // ---------------------------------------------------------------------
  // Operand conditioning at the IDLE -> MUL/DIV edge
  // ---------------------------------------------------------------------
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_launch;

  assign w_signed = ~i_op[0];
  assign w_a_neg  = w_signed & i_operand_a[WIDTH-1];
  assign w_b_neg  = w_signed & i_operand_b[WIDTH-1];
  // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
  assign w_a_mag  = w_a_neg ? (-i_operand_a) : i_operand_a;
  assign w_b_mag  = w_b_neg ? (-i_operand_b) : i_operand_b;
  assign w_launch = (r_state == S_IDLE) && i_start;

  // ---------------------------------------------------------------------
  // Multiply step: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right by one.
  // ---------------------------------------------------------------------
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_a_mag} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // ---------------------------------------------------------------------
  // Divide step: shift the next dividend bit into the remainder (33-bit
  // trial value) and subtract the divisor when it fits.
  // ---------------------------------------------------------------------
  logic [WIDTH:0]     w_div_shift;
  logic               w_div_fits;
  logic [WIDTH-1:0]   w_div_sub;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_fits  = (w_div_shift >= {1'b0, r_b_mag});
  // When the divisor fits the true difference is below 2^32, so the
  // truncated subtraction is exact.
  assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_b_mag;
  assign w_div_next  = {(w_div_fits ? w_div_sub : w_div_shift[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_div_fits};

  // ---------------------------------------------------------------------
  // Sign fixup of the final iteration's result
  // ---------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_div_hi;
  logic [WIDTH-1:0]   w_div_lo;

  assign w_prod_fix = r_neg_res ? (-w_mul_next) : w_mul_next;
  assign w_quo      = w_div_next[WIDTH-1:0];
  assign w_rem      = w_div_next[2*WIDTH-1:WIDTH];
  assign w_quo_fix  = r_neg_res ? (-w_quo) : w_quo;
  assign w_rem_fix  = r_neg_rem ? (-w_rem) : w_rem;
  // Divide by zero bypasses the iterative result entirely.
  assign w_div_hi   = r_div_zero ? r_a_raw : w_rem_fix;
  assign w_div_lo   = r_div_zero ? {WIDTH{1'b1}} : w_quo_fix;

  // ---------------------------------------------------------------------
  // Control FSM and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 5'd0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_a_mag    <= '0;
      r_b_mag    <= '0;
      r_a_raw    <= '0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div_zero <= 1'b0;
      r_acc      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_cnt      <= 5'd0;
            r_a_mag    <= w_a_mag;
            r_b_mag    <= w_b_mag;
            r_a_raw    <= i_operand_a;
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            r_div_zero <= (i_operand_b == '0);
            if (i_op[1]) begin
              r_state <= S_DIV;
              r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
            end else begin
              r_state <= S_MUL;
              r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
            end
          end else begin
            if (i_write_hi) r_hi <= i_write_data;
            if (i_write_lo) r_lo <= i_write_data;
          end
        end

        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == LAST_ITER) begin
            r_hi    <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo    <= w_prod_fix[WIDTH-1:0];
            r_state <= S_DONE;
          end
        end

        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == LAST_ITER) begin
            r_hi    <= w_div_hi;
            r_lo    <= w_div_lo;
            r_state <= S_DONE;
          end
        end

        // The instruction that started the op is still in EX here, so
        // i_start is deliberately ignored.
        S_DONE: begin
          r_cnt   <= 5'd0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy = w_launch || (r_state == S_MUL) || (r_state == S_DIV);
  assign o_done = (r_state == S_DONE);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wd;
  logic        wh, wl;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int passed = 0;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
    .i_operand_a(a), .i_operand_b(b),
    .i_write_hi(wh), .i_write_lo(wl), .i_write_data(wd),
    .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Architectural result {HI, LO} of one mul/div instruction.
  function automatic logic [63:0] ref_calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] p;
    int sx, sy, q, r;
    case (o)
      2'd0: begin
        p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        return p;
      end
      2'd1: return {32'd0, x} * {32'd0, y};
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (o == 2'd3) return {x % y, x / y};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sx = x; sy = y;
        q = sx / sy;
        r = sx % sy;
        return {32'(r), 32'(q)};
      end
    endcase
  endfunction

  // Behavioural model: an op occupies 32 cycles after its launch cycle,
  // then one DONE cycle with the result already in HI/LO.
  int          m_timer;
  logic        m_done;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_timer <= 0;
      m_done  <= 1'b0;
      m_hi    <= 32'd0;
      m_lo    <= 32'd0;
      m_pend  <= 64'd0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_timer > 0) begin
      m_timer <= m_timer - 1;
      if (m_timer == 1) begin
        m_hi   <= m_pend[63:32];
        m_lo   <= m_pend[31:0];
        m_done <= 1'b1;
      end
    end else if (start) begin
      m_pend  <= ref_calc(op, a, b);
      m_timer <= 32;
    end else begin
      if (wh) m_hi <= wd;
      if (wl) m_lo <= wd;
    end
  end

  function automatic logic exp_busy();
    return ((m_timer == 0) && !m_done && start) || (m_timer > 0);
  endfunction

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(exp_busy()));
    chk("done", 32'(done), 32'(m_done));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  // One mul/div instruction. Cycle n=0 is the launch cycle T.
  //   hold   : keep Start high through DONE (T+33)
  //   wmode  : 0 none, 1 random MTHI/MTLO every cycle, 2 MTHI 0xABCD during MUL
  //   rnd_ops: scramble operands/op after launch
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit hold, input int wmode, input bit rnd_ops);
    int bc, dc, da;
    logic [35:0] bseen;
    @(negedge clk); #1;
    op = o; a = x; b = y; start = 1'b1;
    wh = (wmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    wl = (wmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    wd = $urandom;
    bc = 0; dc = 0; da = -1; bseen = '0;
    for (int n = 0; n < 36; n++) begin
      #1;
      bseen[n] = busy;
      if (busy) bc++;
      if (done) begin dc++; da = n; end
      @(negedge clk); #1;
      start = hold && ((n + 1) <= 33);
      if (rnd_ops) begin a = $urandom; b = $urandom; op = 2'($urandom); end
      case (wmode)
        1: begin wh = 1'($urandom_range(0, 1)); wl = 1'($urandom_range(0, 1)); wd = $urandom; end
        2: begin wh = ((n + 1) <= 32); wl = 1'b0; wd = 32'h0000_ABCD; end
        default: begin wh = 1'b0; wl = 1'b0; end
      endcase
    end
    start = 1'b0; wh = 1'b0; wl = 1'b0;
    chk("busy_cycles", 32'(bc), 32'd33);
    chk("done_pulses", 32'(dc), 32'd1);
    chk("done_cycle", 32'(da), 32'd33);
    chk("busy_T33", 32'(bseen[33]), 32'd0);
    chk("busy_T34", 32'(bseen[34]), 32'd0);
  endtask

  // Literal pin on both DUT and model for a hand-computed case.
  task automatic pin(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] ehi, input logic [31:0] elo);
    logic [63:0] m;
    m = ref_calc(o, x, y);
    chk({nm, "_hi"}, hi, ehi);
    chk({nm, "_lo"}, lo, elo);
    chk({nm, "_model_hi"}, m[63:32], ehi);
    chk({nm, "_model_lo"}, m[31:0], elo);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dcount;
    start = 1'b0; op = 2'd0; a = '0; b = '0; wd = '0; wh = 1'b0; wl = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_done", 32'(done), 32'd0);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b1);
    pin("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 0, 1'b0);
    pin("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, 1'b0);
    pin("mult_min", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 1'b0);
    pin("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(2'd3, 32'd100, 32'd7, 1'b0, 0, 1'b0);
    pin("divu", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    pin("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op(2'd3, 32'd5, 32'd0, 1'b1, 0, 1'b0);
    pin("divu_zero", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);

    // MTLO in IDLE
    @(negedge clk); #1 wl = 1'b1; wd = 32'h0000_1234;
    @(negedge clk); #1 wl = 1'b0;
    chk("mtlo", lo, 32'h0000_1234);

    // MTHI while multiplying is ignored
    run_op(2'd1, 32'd3, 32'd5, 1'b0, 2, 1'b0);
    pin("mthi_ignored", 2'd1, 32'd3, 32'd5, 32'd0, 32'd15);

    // Reset at iteration 10 of a MULTU
    @(negedge clk); #1 op = 2'd1; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk); #1 rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done) dcount++;
    end
    chk("abort_no_done", 32'(dcount), 32'd0);
    run_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 0, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      run_op(2'($urandom), pick_val(), pick_val(), 1'($urandom_range(0, 1)), 1, 1'b1);
    end

    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Multi-cycle integer multiply/divide unit for the EX stage, fed directly by the ID/EX pipeline register's read-data and ALU-instruction outputs. It executes MULT, MULTU, DIV and DIVU iteratively (one result bit per cycle) and holds results in the architectural HI/LO registers. It also services MTHI/MTLO writes. While an operation is in flight it raises a stall request so the hazard logic can freeze IF/ID/EX.

## Interface
- WIDTH, 32, operand and HI/LO width. Only 32 is supported.
- Clk  in  1  pipeline clock; all state changes on the rising edge.
- Rst  in  1  reset; asynchronous, active-high.
- Start  in  1  a mul/div instruction is valid in EX (decoded from EX_ALUInstruction).
- Op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- OperandA  in  32  rs value (EX_ReadData1); multiplicand or dividend.
- OperandB  in  32  rt value (EX_ReadData2); multiplier or divisor.
- WriteHi  in  1  MTHI: load HI from WriteData.
- WriteLo  in  1  MTLO: load LO from WriteData.
- WriteData  in  32  data for MTHI/MTLO.
- Busy  out  1  stall request to the hazard unit; combinational.
- Done  out  1  one-cycle pulse when HI/LO receive a new mul/div result.
- HI  out  32  HI register.
- LO  out  32  LO register.

## Operation
- **States:** IDLE, MUL, DIV, DONE. A 5-bit iteration counter runs 0..31.
- **IDLE to MUL/DIV:** taken when Start=1.
  - OperandA, OperandB and Op are latched.
  - For signed ops, operand magnitudes (two's-complement absolute values) are latched, together with the result sign flags.
  - The counter is cleared.
  - Op[1]=0 selects MUL; Op[1]=1 selects DIV.
- **MUL:** unsigned shift-add on the magnitudes, one multiplier bit per cycle, into a 64-bit accumulator.
- **DIV:** restoring division on the magnitudes, one quotient bit per cycle. A 33-bit partial remainder holds the trial subtract.
- **Completion (counter = 31):**
  - Sign fixup is applied and HI/LO are written; the state goes to DONE.
  - MUL writes HI = product[63:32] and LO = product[31:0]. The 64-bit product is negated if the operand signs differ (signed op only).
  - DIV writes LO = quotient and HI = remainder. For signed ops, the quotient is negated if the operand signs differ, and the remainder takes the dividend's sign (truncating division).
- **DONE to IDLE:** always, after one cycle. Start is ignored in DONE, because the same instruction is still in EX during that cycle.
- **Divide by zero:** same latency as a normal divide, no exception. Result is LO = 0xFFFFFFFF and HI = OperandA, regardless of signedness.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- **MTHI/MTLO:** WriteHi/WriteLo are honoured only in IDLE with Start=0, and update the register on that edge. WriteHi and WriteLo together write both HI and LO.
- **Ignored writes:**
  - In MUL, DIV or DONE, writes are ignored; the hazard unit keeps them stalled via Busy.
  - Start and a write together in IDLE: Start wins and the write is dropped.
- **Busy:** Busy = (IDLE && Start) || MUL || DIV. Busy is 0 in DONE, so the stalled instruction advances at the end of the DONE cycle.
- **Done:** Done = (state == DONE).

## Timing
- **Reset values:** state IDLE, counter 0, HI = 0, LO = 0, Done = 0. Busy = Start, since Busy is combinational in IDLE.
- **Reset mid-operation:** aborts the operation immediately (asynchronous). HI/LO are cleared to 0 and no Done pulse is produced.
- **Latency:** if Start is first high in cycle T:
  - Busy is high in cycles T..T+32 (33 cycles).
  - MUL/DIV occupies T+1..T+32 (32 iterations).
  - HI/LO take the new value at the edge ending T+32.
  - Done = 1 and Busy = 0 in T+33; the state is IDLE in T+34.
- **Back-to-back ops:** the next mul/div can enter EX at T+34 and starts with no bubble.
- **Read timing:** HI/LO are stable at all times except on their update edge. MFHI/MFLO reads in the DONE cycle see the new values.
- **Input sampling:** operands are sampled only at the IDLE-to-MUL/DIV edge. Later changes on OperandA/OperandB have no effect.

## Test plan
- Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF → Busy high for exactly 33 cycles, Done pulses once in cycle T+33, HI = 0xFFFFFFFE, LO = 0x00000001.
- MULT 0xFFFFFFFD (−3) × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. Then MULT 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 7 → LO = 14, HI = 2. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU 5 / 0 → 33-cycle Busy, LO = 0xFFFFFFFF, HI = 5. Start held high through DONE does not restart the unit (Busy = 0 at T+33 and T+34).
- MTLO 0x1234 in IDLE → LO = 0x1234 next cycle. WriteHi = 0xABCD asserted during MUL → ignored; HI is the product at completion.
- Assert Rst at iteration 10 of a MULTU → HI = LO = 0 immediately, Done never pulses, Busy = 0 with Start low. A new Start after reset completes normally.
